// File: rtl/text_ram_arbiter_if.sv
// Bus bundle between the text RAM arbiter, its two requesters (display fetcher, host
// register port) and the single-port text-cell RAM. The slave modport is the arbiter;
// the master modport is everything around it (requesters plus the RAM itself).
// Optional feature macro used by the arbiter: OGEGE_ARB_STARVE_GUARD_EN.
interface text_ram_arbiter_if #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
);
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_valid;
    logic [DW-1:0] disp_data;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
        output disp_gnt, disp_valid, disp_data, host_ack, host_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
        input  disp_gnt, disp_valid, disp_data, host_ack, host_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/text_ram_arbiter.sv
// Text-cell RAM arbiter: display scan-out has fixed priority, the host register port
// uses idle RAM cycles through a req/ack handshake. One RAM command per cycle, issued
// the cycle after the grant; read data returns one cycle after that.
// Optional feature: define OGEGE_ARB_STARVE_GUARD_EN to force a host slot after
// STARVE_MAX consecutive display grants while the host is waiting.
module text_ram_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
`ifdef OGEGE_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_MAX = 8
`endif
) (
    input logic               clk_i,
    input logic               rst_i,
    text_ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {HIdle, HCmd, HRd} host_state_e;

    host_state_e   host_state_q, host_state_d;
    logic          host_we_q;
    logic [DW-1:0] host_rdata_q;
    logic          disp_s1_q, disp_s2_q;
    logic [DW-1:0] disp_data_q;
    logic          ram_en_q, ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          disp_gnt, host_gnt, force_host;

`ifdef OGEGE_ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_q, starve_d;

    assign force_host = (host_state_q == HIdle) && bus.host_req && (starve_q >= CW'(STARVE_MAX));

    // Count display grants the waiting host has lost; saturate at the limit.
    always_comb begin
        starve_d = starve_q;
        if (host_gnt || !bus.host_req) begin
            starve_d = '0;
        end else if ((host_state_q == HIdle) && disp_gnt && (starve_q < CW'(STARVE_MAX))) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_host = 1'b0;
`endif

    // Display wins unless a forced host slot is due; nothing is granted in reset.
    always_comb begin
        disp_gnt = bus.disp_req && !rst_i && !force_host;
        host_gnt = (host_state_q == HIdle) && bus.host_req && !rst_i && !disp_gnt;
    end

    // Host FSM next state.
    always_comb begin
        host_state_d = host_state_q;
        unique case (host_state_q)
            HIdle:   if (host_gnt) host_state_d = HCmd;
            HCmd:    host_state_d = host_we_q ? HIdle : HRd;
            HRd:     host_state_d = HIdle;
            default: host_state_d = HIdle;
        endcase
    end

    // Host FSM state and latched transaction type; read data kept after the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            host_state_q <= HIdle;
            host_we_q    <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_state_q <= host_state_d;
            if (host_gnt) host_we_q <= bus.host_we;
            if (host_state_q == HRd) host_rdata_q <= bus.ram_rdata;
        end
    end

    // Registered RAM command from this cycle's grant; addr/wdata hold when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q <= disp_gnt || host_gnt;
            ram_we_q <= host_gnt && bus.host_we;
            if (disp_gnt) begin
                ram_addr_q <= bus.disp_addr;
            end else if (host_gnt) begin
                ram_addr_q  <= bus.host_addr;
                ram_wdata_q <= bus.host_wdata;
            end
        end
    end

    // Display read pipeline: grant -> command -> data; last data held between pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp_s1_q   <= 1'b0;
            disp_s2_q   <= 1'b0;
            disp_data_q <= '0;
        end else begin
            disp_s1_q <= disp_gnt;
            disp_s2_q <= disp_s1_q;
            if (disp_s2_q) disp_data_q <= bus.ram_rdata;
        end
    end

    assign bus.disp_gnt   = disp_gnt;
    assign bus.disp_valid = disp_s2_q;
    assign bus.disp_data  = disp_s2_q ? bus.ram_rdata : disp_data_q;
    assign bus.host_ack   = !rst_i && (((host_state_q == HCmd) && host_we_q) ||
                                       (host_state_q == HRd));
    assign bus.host_rdata = (host_state_q == HRd) ? bus.ram_rdata : host_rdata_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;

endmodule
